// File: rtl/psum_accumulator.sv
// psum_accumulator
// Consumes signed partial sums from the upstream adder tree and adds a
// programmable number of them into one output-channel pixel. It then adds the
// bias, requantizes with an arithmetic right shift, applies an activation
// (none / ReLU / ReLU6), saturates to OUT_W and presents the result on a
// valid/ready port.
//
// Optional build macro: PSUM_ROUND_EN
//   defined   -> round to nearest (half toward +inf) before the shift
//   undefined -> plain arithmetic shift (truncation toward -inf)
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     partial-sum handshake
//   in_data               signed partial sum
//   num_groups            partial sums per output (0 is treated as 1)
//   bias, shift, act_sel  per-pixel configuration
//   out_valid/out_ready   result handshake
//   out_data              saturated signed result
//
// num_groups, bias, shift and act_sel are sampled on the first beat only.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is a combinational function of state. Once out_valid is high it
// stays high, with out_data stable, until the edge where out_ready is high.
module psum_accumulator #(
  parameter int IN_W  = 14,
  parameter int ACC_W = 24,
  parameter int OUT_W = 14,
  parameter int CNT_W = 10,
  parameter int FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic [CNT_W-1:0]        num_groups,
  input  logic signed [ACC_W-1:0] bias,
  input  logic [4:0]              shift,
  input  logic [1:0]              act_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    BIAS  = 3'd2,
    ACT   = 3'd3,
    OUT   = 3'd4
  } state_t;

  // The shift stage works in a width wide enough that the rounding constant
  // (up to 1 << 30) can never overflow the sum.
  localparam int EXT_W = ACC_W + 32;
  localparam logic signed [EXT_W-1:0] OUT_MAX   = (EXT_W'(1) <<< (OUT_W-1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] OUT_MIN   = -(EXT_W'(1) <<< (OUT_W-1));
  localparam logic signed [EXT_W-1:0] RELU6_MAX = EXT_W'(6) <<< FRAC;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         ngrp_q, ngrp_d;
  logic signed [ACC_W-1:0]  bias_q, bias_d;
  logic [4:0]               shift_q, shift_d;
  logic [1:0]               act_q, act_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;

  logic                     beat;
  logic signed [ACC_W-1:0]  in_ext;
  logic signed [EXT_W-1:0]  acc_ext;
  logic signed [EXT_W-1:0]  rnd_c;
  logic signed [EXT_W-1:0]  r_sh;
  logic signed [EXT_W-1:0]  r_act;
  logic signed [OUT_W-1:0]  sat_val;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign beat      = in_valid && in_ready;
  assign in_ext    = ACC_W'(in_data);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Requantize, activate and saturate the current accumulator value.
  always_comb begin
    acc_ext = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    rnd_c   = '0;
`ifdef PSUM_ROUND_EN
    if (shift_q != 5'd0) rnd_c = EXT_W'(1) <<< (shift_q - 5'd1);
`endif
    // Shifts of ACC_W or more leave only sign fill (0 or -1).
    r_sh = (acc_ext + rnd_c) >>> shift_q;

    r_act = r_sh;
    case (act_q)
      2'd1: if (r_sh < 0) r_act = '0;
      2'd2: begin
        if (r_sh < 0)              r_act = '0;
        else if (r_sh > RELU6_MAX) r_act = RELU6_MAX;
      end
      default: r_act = r_sh;
    endcase

    if (r_act > OUT_MAX)      sat_val = OUT_MAX[OUT_W-1:0];
    else if (r_act < OUT_MIN) sat_val = OUT_MIN[OUT_W-1:0];
    else                      sat_val = r_act[OUT_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ngrp_d      = ngrp_q;
    bias_d      = bias_q;
    shift_d     = shift_q;
    act_d       = act_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d   = in_ext;
          cnt_d   = CNT_W'(1);
          ngrp_d  = num_groups;
          bias_d  = bias;
          shift_d = shift;
          act_d   = act_sel;
          // A count of 0 or 1 both mean a single-beat pixel.
          state_d = (num_groups <= CNT_W'(1)) ? BIAS : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = acc_q + in_ext;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == ngrp_q) state_d = BIAS;
        end
      end
      BIAS: begin
        acc_d   = acc_q + bias_q;
        state_d = ACT;
      end
      ACT: begin
        out_data_d  = sat_val;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ngrp_q      <= '0;
      bias_q      <= '0;
      shift_q     <= '0;
      act_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ngrp_q      <= ngrp_d;
      bias_q      <= bias_d;
      shift_q     <= shift_d;
      act_q       <= act_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed testbench for psum_accumulator. Inputs are driven and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_psum_accumulator;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [13:0] in_data;
  logic [9:0]         num_groups;
  logic signed [23:0] bias;
  logic [4:0]         shift;
  logic [1:0]         act_sel;
  logic               out_valid;
  logic               out_ready;
  logic signed [13:0] out_data;

  int total_cnt;
  int bad_cnt;
  int pkt_q[$];

  psum_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .num_groups (num_groups),
    .bias       (bias),
    .shift      (shift),
    .act_sel    (act_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total_cnt++;
    if (got != exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic drive_beat(input int v, input int ng, input int b, input int sh, input int act);
    int t;
    in_valid   = 1'b1;
    in_data    = v[13:0];
    num_groups = ng[9:0];
    bias       = b[23:0];
    shift      = sh[4:0];
    act_sel    = act[1:0];
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int ng, input int b, input int sh, input int act, input int gap);
    int n;
    n = pkt_q.size();
    for (int i = 0; i < n; i++) begin
      drive_beat(pkt_q[i], ng, b, sh, act);
      if (i != n - 1) begin
        chk("accum_in_ready", int'(in_ready), 1);
        repeat (gap) @(negedge clk);
      end
    end
    pkt_q.delete();
  endtask

  // Entered on the falling edge right after the last beat was accepted.
  task automatic check_result(input string tag, input int exp);
    chk({tag, "_bias_valid"}, int'(out_valid), 0);
    chk({tag, "_bias_ready"}, int'(in_ready), 0);
    @(negedge clk);
    chk({tag, "_act_valid"}, int'(out_valid), 0);
    chk({tag, "_act_ready"}, int'(in_ready), 0);
    @(negedge clk);
    chk({tag, "_out_valid"}, int'(out_valid), 1);
    chk({tag, "_out_ready_low"}, int'(in_ready), 0);
    chk({tag, "_data"}, int'(out_data), exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, int'(out_valid), 0);
    chk({tag, "_idle_ready"}, int'(in_ready), 1);
    chk({tag, "_data_kept"}, int'(out_data), exp);
  endtask

  initial begin
    total_cnt  = 0;
    bad_cnt    = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    num_groups = '0;
    bias       = '0;
    shift      = '0;
    act_sel    = '0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Single group, no activation: 100 + 20
    pkt_q = '{100};
    send_pkt(1, 20, 0, 0, 0);
    check_result("single", 120);

    // Three groups with ReLU: (850 - 50) >>> 2 = 200
    pkt_q = '{1000, -200, 50};
    send_pkt(3, -50, 2, 1, 2);
    check_result("relu_pos", 200);

    // (850 - 2000) >>> 2 is negative, ReLU gives 0
    pkt_q = '{1000, -200, 50};
    send_pkt(3, -2000, 2, 1, 2);
    check_result("relu_neg", 0);

    // ReLU6 ceiling is 6 << 8 = 1536
    pkt_q = '{4000};
    send_pkt(1, 0, 0, 2, 0);
    check_result("relu6_hi", 1536);
    pkt_q = '{-300};
    send_pkt(1, 0, 0, 2, 0);
    check_result("relu6_lo", 0);
    pkt_q = '{1000};
    send_pkt(1, 0, 0, 2, 0);
    check_result("relu6_mid", 1000);

    // Output saturation
    pkt_q = '{8191, 8191};
    send_pkt(2, 0, 0, 0, 0);
    check_result("sat_pos", 8191);
    pkt_q = '{-8192, -8192};
    send_pkt(2, 0, 0, 0, 0);
    check_result("sat_neg", -8192);

    // Zero group count behaves as one
    pkt_q = '{7};
    send_pkt(0, 0, 0, 0, 0);
    check_result("zero_groups", 7);

    // Bias add wraps in 24 bits: 0x7FFFFF + 1 -> -2^23, then saturates low
    pkt_q = '{1};
    send_pkt(1, 8388607, 0, 0, 0);
    check_result("acc_wrap", -8192);

    // Rounding and oversized shifts
    pkt_q = '{-5};
    send_pkt(1, 0, 1, 0, 0);
`ifdef PSUM_ROUND_EN
    check_result("round_neg", -2);
`else
    check_result("round_neg", -3);
`endif
    pkt_q = '{5};
    send_pkt(1, 0, 1, 0, 0);
`ifdef PSUM_ROUND_EN
    check_result("round_pos", 3);
`else
    check_result("round_pos", 2);
`endif
    pkt_q = '{-5};
    send_pkt(1, 0, 30, 0, 0);
`ifdef PSUM_ROUND_EN
    check_result("big_shift", 0);
`else
    check_result("big_shift", -1);
`endif

    // Back-pressure: result 42 held while a new beat (9) waits upstream
    pkt_q = '{42};
    send_pkt(1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = 14'sd9;
    num_groups = 10'd1;
    bias       = '0;
    shift      = '0;
    act_sel    = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), 42);
      chk("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_hs_valid", int'(out_valid), 0);
    chk("bp_hs_in_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check_result("bp_next", 9);

    // Reset in the middle of a 4-group accumulation
    pkt_q = '{10, 20};
    send_pkt(4, 0, 0, 0, 0);
    chk("mid_accum_ready", int'(in_ready), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    chk("mid_rst_no_pulse", int'(out_valid), 0);
    pkt_q = '{5};
    send_pkt(1, 0, 0, 0, 0);
    check_result("after_rst", 5);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
